bf_io_responder: RTL and testbench
==================================

Name: bf_io_responder

Overview:
- Responder side of the bfX core's I/O instruction path.
- Serves the core's `,` (read byte) and `.` (write byte) requests from two small FIFOs.
  - RX FIFO: filled by the host, drained by the core.
  - TX FIFO: filled by the core, drained by the host.
- Sits between the bfX core and the host/testbench. Stalls the core while a request cannot be served.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, ≥2.
- AW, 2, log2(DEPTH); count outputs are AW+1 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- io_req  in  1  core I/O request; held high until io_ack
- io_dir  in  1  0 = read (`,`), 1 = write (`.`); stable while io_req high
- io_wdata  in  8  byte to output; stable while io_req high
- io_rdata  out  8  byte returned for a read; valid when io_ack=1, held until the next read ack
- io_ack  out  1  one-cycle completion pulse
- io_stall  out  1  high while a request is accepted but not yet served
- host_in_valid  in  1  host offers an input byte
- host_in_data  in  8  input byte
- host_in_ready  out  1  RX FIFO can accept (= !rx_full)
- host_out_valid  out  1  TX FIFO non-empty
- host_out_data  out  8  head of TX FIFO (first-word fall-through)
- host_out_ready  in  1  host consumes head
- rx_count  out  AW+1  RX occupancy
- tx_count  out  AW+1  TX occupancy

Behaviour:
- Reset (asynchronous, while rst_n=0), all outputs and state cleared:
  - io_rdata=0, io_ack=0, io_stall=0, state=IDLE.
  - Both FIFOs empty: rx_count=0, tx_count=0, host_in_ready=1, host_out_valid=0, host_out_data=0.
  - Any request in flight is dropped with no ack. No FIFO push or pop occurs in a cycle where rst_n=0.
- FIFOs: circular buffers, AW-bit pointers wrap modulo DEPTH, separate count registers.
  - Host push when host_in_valid & host_in_ready.
  - Host pop when host_out_valid & host_out_ready.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on io_req=1, latch io_dir and io_wdata and go to WAIT. io_stall=0.
  - WAIT: io_stall=1.
    - Write: if TX not full, push the latched byte, go to ACK.
    - Read: if RX not empty, pop the head into io_rdata, go to ACK.
    - Otherwise remain in WAIT indefinitely (no timeout).
  - ACK: io_ack=1 and io_stall=0 for exactly one cycle, then IDLE. io_req is ignored in ACK; the core drops it upon seeing io_ack.
- Latency when the FIFO is ready: request sampled at edge N, transfer at edge N+1, io_ack high during cycle N+1..N+2. Minimum 3 cycles between back-to-back requests.
- Simultaneous events:
  - TX: a core push and a host pop in the same edge are both allowed. tx_count is unchanged, and the push is legal even when full because the pop frees the slot that cycle.
  - RX: host_in_ready depends only on rx_full (no pass-through). A host push and a core pop in the same edge are both allowed and rx_count is unchanged. When RX is full, a host push is refused even if the core pops that edge.
- Read from empty RX: remain in WAIT. Serve on the edge after the first host push has registered; the byte is not forwarded combinationally in the push cycle.
- Write while TX full: remain in WAIT until a host pop frees a slot. If the pop coincides with a WAIT cycle, the push happens on that same edge.
- io_rdata changes only on a read transfer edge; writes never alter it.
- Counts saturate structurally: never exceed DEPTH, never underflow. Ignoring host_in_ready (pushing while full) is a host protocol error; such a push is dropped.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT with 2 bytes in TX. Required after release: io_ack=0, tx_count=0, host_out_valid=0, state IDLE. No ack is ever produced for the dropped request.
- Write path: io_req=1, io_dir=1, io_wdata=0x41 at edge 0. Required: io_ack pulse in cycle 1–2, tx_count=1, host_out_data=0x41, host_out_valid=1. Host pops → tx_count=0.
- Read stall: io_req read with RX empty; io_stall=1 for 10 cycles. Host pushes 0x7F at edge 10. Required: transfer at edge 11, io_rdata=0x7F, io_ack for one cycle, rx_count returns to 0.
- TX full: 4 writes 0x01..0x04 with host_out_ready=0, then a 5th write 0x05. Required: the 5th stalls; raising host_out_ready for one cycle pops 0x01 and pushes 0x05 on the same edge, tx_count stays 4. Drain order is 0x02,0x03,0x04,0x05.
- RX wrap: host pushes 0x10..0x15 interleaved with 6 core reads. Required: data returned in order across pointer wrap, and host_in_ready=0 whenever rx_count=4.
- Simultaneous: with RX at rx_count=2, a host push and a core read transfer on the same edge. Required: rx_count stays 2 and io_rdata equals the oldest byte.

Source files
------------

// File: rtl/bf_io_responder.sv
// I/O responder for the bfX core: serves `,` reads from an RX FIFO and `.` writes
// into a TX FIFO, stalling the core while the addressed FIFO cannot take part.
module bf_io_responder #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          io_req,
   input  logic          io_dir,
   input  logic [7:0]    io_wdata,
   output logic [7:0]    io_rdata,
   output logic          io_ack,
   output logic          io_stall,
   input  logic          host_in_valid,
   input  logic [7:0]    host_in_data,
   output logic          host_in_ready,
   output logic          host_out_valid,
   output logic [7:0]    host_out_data,
   input  logic          host_out_ready,
   output logic [AW:0]   rx_count,
   output logic [AW:0]   tx_count,
   output logic [1:0]    dbg_state
);

   // Handshakes: a byte moves on a rising edge where valid and ready are both high;
   // ready never depends combinationally on valid, and valid/data hold until accepted.

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [1:0]    r_state;
   logic          r_dir;
   logic [7:0]    r_wdata;
   logic [7:0]    r_rdata;

   logic [7:0]    r_rx_mem [DEPTH];
   logic [AW-1:0] r_rx_wp;
   logic [AW-1:0] r_rx_rp;
   logic [AW:0]   r_rx_cnt;

   logic [7:0]    r_tx_mem [DEPTH];
   logic [AW-1:0] r_tx_wp;
   logic [AW-1:0] r_tx_rp;
   logic [AW:0]   r_tx_cnt;

   logic w_rx_full;
   logic w_rx_empty;
   logic w_tx_full;
   logic w_tx_empty;
   logic w_host_push;
   logic w_host_pop;
   logic w_core_push;
   logic w_core_pop;

   assign w_rx_full   = (r_rx_cnt == FULL_CNT);
   assign w_rx_empty  = (r_rx_cnt == '0);
   assign w_tx_full   = (r_tx_cnt == FULL_CNT);
   assign w_tx_empty  = (r_tx_cnt == '0);

   assign w_host_push = host_in_valid & ~w_rx_full;
   assign w_host_pop  = host_out_ready & ~w_tx_empty;
   assign w_core_pop  = (r_state == S_WAIT) & ~r_dir & ~w_rx_empty;
   // A full TX still accepts the core's byte when the host frees the head slot this edge.
   assign w_core_push = (r_state == S_WAIT) & r_dir & (~w_tx_full | w_host_pop);

   assign host_in_ready  = ~w_rx_full;
   assign host_out_valid = ~w_tx_empty;
   assign host_out_data  = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp];
   assign rx_count       = r_rx_cnt;
   assign tx_count       = r_tx_cnt;
   assign io_rdata       = r_rdata;
   assign io_ack         = (r_state == S_ACK);
   assign io_stall       = (r_state == S_WAIT);
   assign dbg_state      = r_state;

   always_ff @(posedge clk) begin
      if (w_host_push) r_rx_mem[r_rx_wp] <= host_in_data;
      if (w_core_push) r_tx_mem[r_tx_wp] <= r_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_host_push) r_rx_wp <= r_rx_wp + AW'(1);
         if (w_core_pop)  r_rx_rp <= r_rx_rp + AW'(1);
         case ({w_host_push, w_core_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
      end else begin
         if (w_core_push) r_tx_wp <= r_tx_wp + AW'(1);
         if (w_host_pop)  r_tx_rp <= r_tx_rp + AW'(1);
         case ({w_core_push, w_host_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dir   <= 1'b0;
         r_wdata <= 8'h00;
         r_rdata <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_req) begin
                  r_dir   <= io_dir;
                  r_wdata <= io_wdata;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_core_pop) r_rdata <= r_rx_mem[r_rx_rp];
               if (w_core_pop | w_core_push) r_state <= S_ACK;
            end
            S_ACK:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bf_io_responder.sv
// Bench for bf_io_responder: vector table, directed corner sequences and a
// randomized run compared against a queue-based transaction model.
module tb_bf_io_responder;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   localparam int OP_CW    = 0;
   localparam int OP_CR    = 1;
   localparam int OP_HPUSH = 2;
   localparam int OP_HPOP  = 3;

   typedef struct {
      int         op;
      logic [7:0] din;
      logic [7:0] exp_data;
      logic [2:0] exp_rx;
      logic [2:0] exp_tx;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        io_req = 1'b0;
   logic        io_dir = 1'b0;
   logic [7:0]  io_wdata = 8'h00;
   logic [7:0]  io_rdata;
   logic        io_ack;
   logic        io_stall;
   logic        host_in_valid = 1'b0;
   logic [7:0]  host_in_data = 8'h00;
   logic        host_in_ready;
   logic        host_out_valid;
   logic [7:0]  host_out_data;
   logic        host_out_ready = 1'b0;
   logic [AW:0] rx_count;
   logic [AW:0] tx_count;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   // transaction-level reference state
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];
   bit         m_pending;
   bit         m_dir;
   logic [7:0] m_wdata;
   bit         m_ack;
   logic [7:0] m_rdata;

   bf_io_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .io_req(io_req), .io_dir(io_dir), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ack(io_ack), .io_stall(io_stall),
      .host_in_valid(host_in_valid), .host_in_data(host_in_data),
      .host_in_ready(host_in_ready),
      .host_out_valid(host_out_valid), .host_out_data(host_out_data),
      .host_out_ready(host_out_ready),
      .rx_count(rx_count), .tx_count(tx_count), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_push(input logic [7:0] b);
      host_in_valid = 1'b1;
      host_in_data  = b;
      tick();
      host_in_valid = 1'b0;
   endtask

   task automatic host_pop(input logic [7:0] exp);
      check("pop_valid", 32'(host_out_valid), 32'd1);
      check("pop_data", 32'(host_out_data), 32'(exp));
      host_out_ready = 1'b1;
      tick();
      host_out_ready = 1'b0;
   endtask

   task automatic core_op(input bit dir, input logic [7:0] wd, output int lat);
      io_req   = 1'b1;
      io_dir   = dir;
      io_wdata = wd;
      lat      = 0;
      while (!io_ack && lat < 50) begin
         tick();
         lat++;
      end
      if (!io_ack) check("core_ack_timeout", 32'd0, 32'd1);
      io_req = 1'b0;
      tick();
      check("ack_one_cycle", 32'(io_ack), 32'd0);
   endtask

   task automatic model_reset();
      rx_q.delete();
      tx_q.delete();
      m_pending = 1'b0;
      m_dir     = 1'b0;
      m_wdata   = 8'h00;
      m_ack     = 1'b0;
      m_rdata   = 8'h00;
   endtask

   task automatic do_reset();
      io_req = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      model_reset();
   endtask

   // Advance the reference by one edge using the inputs currently driven.
   task automatic model_step();
      bit h_push, h_pop, serve;
      h_push = host_in_valid && (rx_q.size() < DEPTH);
      h_pop  = host_out_ready && (tx_q.size() > 0);
      serve  = 1'b0;
      if (m_pending)
         serve = m_dir ? ((tx_q.size() < DEPTH) || h_pop) : (rx_q.size() > 0);
      if (h_pop) void'(tx_q.pop_front());
      if (serve && !m_dir) m_rdata = rx_q.pop_front();
      if (serve && m_dir) tx_q.push_back(m_wdata);
      if (h_push) rx_q.push_back(host_in_data);
      if (serve) m_pending = 1'b0;
      else if (!m_pending && !m_ack && io_req) begin
         m_pending = 1'b1;
         m_dir     = io_dir;
         m_wdata   = io_wdata;
      end
      m_ack = serve;
   endtask

   task automatic run_random(input int n, input int p_in, input int p_out);
      logic [31:0] exp, act;
      logic [7:0]  head;
      for (int c = 0; c < n; c++) begin
         host_in_valid  = ($urandom_range(99) < p_in);
         host_in_data   = 8'($urandom_range(255));
         host_out_ready = ($urandom_range(99) < p_out);
         if (io_req && m_ack) io_req = 1'b0;
         else if (!io_req && !m_ack && $urandom_range(99) < 50) begin
            io_req   = 1'b1;
            io_dir   = 1'($urandom_range(1));
            io_wdata = 8'($urandom_range(255));
         end
         model_step();
         tick();
         head = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
         exp = {6'd0, m_ack, m_pending, 3'(rx_q.size()), 3'(tx_q.size()),
                (tx_q.size() > 0), head, (rx_q.size() < DEPTH), m_rdata};
         act = {6'd0, io_ack, io_stall, rx_count, tx_count,
                host_out_valid, host_out_data, host_in_ready, io_rdata};
         check("random_cycle", act, exp);
      end
      io_req = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;
   endtask

   initial begin
      vec_t vecs[10];
      int   lat;
      int   cnt;

      vecs[0] = '{OP_CW,    8'h41, 8'h00, 3'd0, 3'd1};
      vecs[1] = '{OP_HPOP,  8'h00, 8'h41, 3'd0, 3'd0};
      vecs[2] = '{OP_HPUSH, 8'h10, 8'h00, 3'd1, 3'd0};
      vecs[3] = '{OP_HPUSH, 8'h11, 8'h00, 3'd2, 3'd0};
      vecs[4] = '{OP_CR,    8'h00, 8'h10, 3'd1, 3'd0};
      vecs[5] = '{OP_CW,    8'h22, 8'h00, 3'd1, 3'd1};
      vecs[6] = '{OP_CW,    8'h33, 8'h00, 3'd1, 3'd2};
      vecs[7] = '{OP_HPOP,  8'h00, 8'h22, 3'd1, 3'd1};
      vecs[8] = '{OP_CR,    8'h00, 8'h11, 3'd0, 3'd1};
      vecs[9] = '{OP_HPOP,  8'h00, 8'h33, 3'd0, 3'd0};

      // reset values
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      check("rst_ack", 32'(io_ack), 32'd0);
      check("rst_stall", 32'(io_stall), 32'd0);
      check("rst_rdata", 32'(io_rdata), 32'd0);
      check("rst_counts", {26'd0, rx_count, tx_count}, 32'd0);
      check("rst_in_ready", 32'(host_in_ready), 32'd1);
      check("rst_out", {23'd0, host_out_valid, host_out_data}, 32'd0);

      // table-driven vectors
      for (int i = 0; i < 10; i++) begin
         case (vecs[i].op)
            OP_CW: begin
               core_op(1'b1, vecs[i].din, lat);
               check("tbl_wr_latency", 32'(lat), 32'd2);
            end
            OP_CR: begin
               core_op(1'b0, 8'h00, lat);
               check("tbl_rd_latency", 32'(lat), 32'd2);
               check("tbl_rd_data", 32'(io_rdata), 32'(vecs[i].exp_data));
            end
            OP_HPUSH: host_push(vecs[i].din);
            default:  host_pop(vecs[i].exp_data);
         endcase
         check("tbl_rx_count", 32'(rx_count), 32'(vecs[i].exp_rx));
         check("tbl_tx_count", 32'(tx_count), 32'(vecs[i].exp_tx));
      end

      // read stall: RX empty for 10 cycles, then one host push
      io_req = 1'b1; io_dir = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (io_stall && !io_ack) cnt++;
      end
      check("stall_cycles", 32'(cnt), 32'd10);
      host_in_valid = 1'b1; host_in_data = 8'h7F;
      tick();
      host_in_valid = 1'b0;
      check("stall_no_bypass_ack", 32'(io_ack), 32'd0);
      check("stall_push_count", 32'(rx_count), 32'd1);
      tick();
      check("stall_ack", 32'(io_ack), 32'd1);
      check("stall_rdata", 32'(io_rdata), 32'h7F);
      check("stall_rx_empty", 32'(rx_count), 32'd0);
      io_req = 1'b0;
      tick();
      check("stall_ack_drop", 32'(io_ack), 32'd0);

      // TX full: fifth write waits until the host frees a slot
      for (int i = 1; i <= 4; i++) core_op(1'b1, 8'(i), lat);
      check("txf_count4", 32'(tx_count), 32'd4);
      io_req = 1'b1; io_dir = 1'b1; io_wdata = 8'h05;
      repeat (3) tick();
      check("txf_stalled", {30'd0, io_stall, io_ack}, 32'b10);
      check("txf_head", 32'(host_out_data), 32'h01);
      host_out_ready = 1'b1;
      tick();
      host_out_ready = 1'b0;
      check("txf_ack", 32'(io_ack), 32'd1);
      check("txf_count_kept", 32'(tx_count), 32'd4);
      io_req = 1'b0;
      tick();
      for (int i = 2; i <= 5; i++) host_pop(8'(i));
      check("txf_drained", 32'(tx_count), 32'd0);

      // RX wrap with simultaneous push/pop and refused push while full
      host_push(8'h10);
      host_push(8'h11);
      io_req = 1'b1; io_dir = 1'b0;
      tick();
      host_in_valid = 1'b1; host_in_data = 8'h12;
      tick();
      host_in_valid = 1'b0;
      check("sim_ack", 32'(io_ack), 32'd1);
      check("sim_rdata", 32'(io_rdata), 32'h10);
      check("sim_rx_count", 32'(rx_count), 32'd2);
      io_req = 1'b0;
      tick();
      host_push(8'h13);
      host_push(8'h14);
      check("wrap_full_count", 32'(rx_count), 32'd4);
      check("wrap_full_ready", 32'(host_in_ready), 32'd0);
      io_req = 1'b1; io_dir = 1'b0;
      tick();
      host_in_valid = 1'b1; host_in_data = 8'h99;
      tick();
      host_in_valid = 1'b0;
      check("full_refuse_rdata", 32'(io_rdata), 32'h11);
      check("full_refuse_count", 32'(rx_count), 32'd3);
      io_req = 1'b0;
      tick();
      for (int i = 2; i <= 4; i++) begin
         core_op(1'b0, 8'h00, lat);
         check("wrap_rdata", 32'(io_rdata), 32'(8'h10 + i));
      end
      host_push(8'h15);
      core_op(1'b0, 8'h00, lat);
      check("wrap_last_rdata", 32'(io_rdata), 32'h15);
      check("wrap_empty", {26'd0, rx_count, 2'd0, host_in_ready}, 32'd1);

      // reset mid-WAIT with two bytes in TX
      core_op(1'b1, 8'hA1, lat);
      core_op(1'b1, 8'hA2, lat);
      io_req = 1'b1; io_dir = 1'b0;
      repeat (3) tick();
      check("rst_pre_stall", 32'(io_stall), 32'd1);
      #2 rst_n = 1'b0;
      io_req = 1'b0;
      host_in_valid = 1'b1; host_in_data = 8'h5C;
      #1;
      check("arst_tx", {23'd0, tx_count, host_out_valid, host_out_data}, 32'd0);
      check("arst_ctrl", {29'd0, io_stall, io_ack, host_in_ready}, 32'd1);
      check("arst_rdata", 32'(io_rdata), 32'd0);
      repeat (2) @(posedge clk);
      #1 check("arst_no_push", 32'(rx_count), 32'd0);
      host_in_valid = 1'b0;
      #2 rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (io_ack || io_stall) cnt++;
      end
      check("rst_no_late_ack", 32'(cnt), 32'd0);
      core_op(1'b1, 8'h5A, lat);
      check("rst_idle_latency", 32'(lat), 32'd2);
      host_pop(8'h5A);

      // randomized run against the reference model
      do_reset();
      run_random(250, 25, 15);
      run_random(250, 70, 70);
      do_reset();
      run_random(250, 80, 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
